// File: rtl/loop_recorder.sv
// Step-sequencer looper: records sanitised note indices into a circular STEPS-slot
// memory and plays them back, with overdub, on a fixed step clock.
module loop_recorder #(
    parameter int STEP_DIV = 6250000,
    parameter int STEPS    = 32,
    parameter int STEP_W   = 5,
    parameter int MAX_NOTE = 26
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [7:0]        note_in,
    input  logic              rec_p,
    input  logic              play_p,
    input  logic              clear_p,
    output logic [7:0]        note_out,
    output logic [STEP_W-1:0] step_idx,
    output logic              beat,
    output logic [1:0]        mode,
    output logic              busy
);

    localparam int TW = $clog2(STEP_DIV);
    localparam logic [TW-1:0]     T_LAST = TW'(STEP_DIV - 1);
    localparam logic [STEP_W-1:0] S_LAST = STEP_W'(STEPS - 1);

    // Encoding doubles as the externally visible mode code.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_REC   = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [STEP_W-1:0] clr_q, clr_d;
    logic [7:0]        cap_q, cap_d;
    logic [7:0]        note_q, note_d;
    logic              beat_q, beat_d;

    logic [7:0]        mem [STEPS];
    logic              we;
    logic [STEP_W-1:0] waddr;
    logic [7:0]        wdata;

    logic [7:0]        live;
    logic [7:0]        cap_eff;
    logic [7:0]        rd;

    assign live    = (note_in > 8'(MAX_NOTE)) ? 8'd0 : note_in;
    // The current cycle still belongs to the step, so a first press here counts.
    assign cap_eff = (cap_q != 8'd0) ? cap_q : live;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            step_q  <= '0;
            clr_q   <= '0;
            cap_q   <= '0;
            note_q  <= '0;
            beat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            step_q  <= step_d;
            clr_q   <= clr_d;
            cap_q   <= cap_d;
            note_q  <= note_d;
            beat_q  <= beat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        step_d  = step_q;
        clr_d   = clr_q;
        cap_d   = 8'd0;
        beat_d  = 1'b0;
        we      = 1'b0;
        waddr   = step_q;
        wdata   = cap_eff;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                step_d  = '0;
                if (clear_p) begin
                    state_d = S_CLEAR;
                    clr_d   = '0;
                end else if (rec_p) begin
                    state_d = S_REC;
                end else if (play_p) begin
                    state_d = S_PLAY;
                end
            end

            S_PLAY, S_REC: begin
                if (timer_q == T_LAST) begin
                    timer_d = '0;
                    step_d  = step_q + 1'b1;
                    beat_d  = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end

                if (state_q == S_REC) begin
                    cap_d = cap_eff;
                    if (timer_q == T_LAST) begin
                        we    = (cap_eff != 8'd0);
                        cap_d = 8'd0;
                    end
                end

                // Commands override the running step; rec_p keeps the timer going.
                if (clear_p) begin
                    state_d = S_CLEAR;
                    clr_d   = '0;
                    timer_d = '0;
                    step_d  = '0;
                    beat_d  = 1'b0;
                    we      = 1'b0;
                    cap_d   = 8'd0;
                end else if (rec_p) begin
                    state_d = (state_q == S_REC) ? S_PLAY : S_REC;
                    if (state_q == S_REC) begin
                        we    = (cap_eff != 8'd0);
                        cap_d = 8'd0;
                    end
                end else if (play_p) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                    step_d  = '0;
                    beat_d  = 1'b0;
                    we      = (state_q == S_REC) && (cap_eff != 8'd0);
                    cap_d   = 8'd0;
                end
            end

            S_CLEAR: begin
                timer_d = '0;
                step_d  = '0;
                we      = 1'b1;
                waddr   = clr_q;
                wdata   = 8'd0;
                clr_d   = clr_q + 1'b1;
                if (clr_q == S_LAST) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Forward this cycle's write so note_out always matches the step it is shown with.
    assign rd = (we && (waddr == step_d)) ? wdata : mem[step_d];

    always_comb begin
        note_d = 8'd0;
        case (state_d)
            S_IDLE:  note_d = live;
            S_PLAY:  note_d = rd;
            S_REC:   note_d = (live != 8'd0) ? live : rd;
            default: note_d = 8'd0;
        endcase
    end

    assign note_out = note_q;
    assign step_idx = step_q;
    assign beat     = beat_q;
    assign mode     = state_q;
    assign busy     = (state_q == S_CLEAR);

endmodule

// File: tb/tb_loop_recorder.sv
// Directed bench for loop_recorder: a rule-level model checked every cycle, plus
// hand-computed literal expectations for the recorded loops and command corner cases.
module tb_loop_recorder;

    localparam int STEP_DIV = 4;
    localparam int STEPS    = 4;
    localparam int STEP_W   = 2;
    localparam int MAX_NOTE = 26;

    logic              clk = 1'b0;
    logic              resetn = 1'b1;
    logic [7:0]        note_in = 8'd0;
    logic              rec_p = 1'b0;
    logic              play_p = 1'b0;
    logic              clear_p = 1'b0;
    logic [7:0]        note_out;
    logic [STEP_W-1:0] step_idx;
    logic              beat;
    logic [1:0]        mode;
    logic              busy;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b1;

    logic [7:0] exp_q[$];

    loop_recorder #(
        .STEP_DIV(STEP_DIV),
        .STEPS   (STEPS),
        .STEP_W  (STEP_W),
        .MAX_NOTE(MAX_NOTE)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .note_in (note_in),
        .rec_p   (rec_p),
        .play_p  (play_p),
        .clear_p (clear_p),
        .note_out(note_out),
        .step_idx(step_idx),
        .beat    (beat),
        .mode    (mode),
        .busy    (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] san(input logic [7:0] n);
        return (n > 8'(MAX_NOTE)) ? 8'd0 : n;
    endfunction

    // ---------------- behavioural model ----------------
    // Modes: 0 idle, 1 play, 2 rec, 3 clear. m_first = first note heard this step.
    int         m_mode, m_step, m_phase, m_first, m_clr, m_cmd;
    logic [7:0] m_live, m_note;
    logic       m_beat;
    logic [7:0] m_mem [STEPS];

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_mode = 0; m_step = 0; m_phase = 0; m_first = 0; m_clr = 0;
            m_note = 8'd0; m_beat = 1'b0;
        end else begin
            m_live = san(note_in);
            m_beat = 1'b0;
            if (clear_p)     m_cmd = 3;
            else if (rec_p)  m_cmd = 2;
            else if (play_p) m_cmd = 1;
            else             m_cmd = 0;

            if (m_mode == 0) begin
                m_step = 0; m_phase = 0;
                if (m_cmd == 3) begin m_mode = 3; m_clr = 0; end
                else if (m_cmd == 2) m_mode = 2;
                else if (m_cmd == 1) m_mode = 1;
            end else if (m_mode == 3) begin
                m_mem[m_clr] = 8'd0;
                m_clr++;
                if (m_clr == STEPS) begin m_mode = 0; m_step = 0; end
            end else begin
                if (m_mode == 2 && m_first == 0) m_first = int'(m_live);
                if (m_cmd == 3) begin
                    m_mode = 3; m_clr = 0; m_first = 0; m_step = 0; m_phase = 0;
                end else if (m_cmd == 1) begin
                    if (m_mode == 2 && m_first != 0) m_mem[m_step] = 8'(m_first);
                    m_first = 0; m_mode = 0; m_step = 0; m_phase = 0;
                end else begin
                    if (m_cmd == 2 && m_mode == 2) begin
                        if (m_first != 0) m_mem[m_step] = 8'(m_first);
                        m_first = 0; m_mode = 1;
                    end else if (m_cmd == 2) begin
                        m_mode = 2;
                    end
                    m_phase++;
                    if (m_phase == STEP_DIV) begin
                        if (m_mode == 2 && m_first != 0) m_mem[m_step] = 8'(m_first);
                        m_first = 0; m_phase = 0; m_beat = 1'b1;
                        m_step = (m_step + 1) % STEPS;
                    end
                end
            end

            case (m_mode)
                0:       m_note = m_live;
                1:       m_note = m_mem[m_step];
                2:       m_note = (m_live != 8'd0) ? m_live : m_mem[m_step];
                default: m_note = 8'd0;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_note_out", 32'(note_out), 32'(m_note));
            chk("model_step_idx", 32'(step_idx), 32'(m_step));
            chk("model_beat",     32'(beat),     32'(m_beat));
            chk("model_mode",     32'(mode),     32'(m_mode));
            chk("model_busy",     32'(busy),     32'(m_mode == 3));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int which);
        rec_p   = (which == 1);
        play_p  = (which == 2);
        clear_p = (which == 3);
        cyc(1);
        rec_p = 1'b0; play_p = 1'b0; clear_p = 1'b0;
    endtask

    // Starts at step 0, timer 0; ends at the same position after the passes.
    task automatic play_pass(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d, input int passes);
        logic [7:0] e;
        for (int p = 0; p < passes; p++) begin
            exp_q.push_back(a); exp_q.push_back(b);
            exp_q.push_back(c); exp_q.push_back(d);
        end
        for (int i = 0; i < passes * STEPS; i++) begin
            e = exp_q.pop_front();
            chk("pass_step", 32'(step_idx), 32'(i % STEPS));
            chk("pass_note", 32'(note_out), 32'(e));
            cyc(STEP_DIV);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        #1 resetn = 1'b0;
        cyc(3);
        chk("reset_mode", 32'(mode), 32'd0);
        chk("reset_note", 32'(note_out), 32'd0);
        chk("reset_step", 32'(step_idx), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_beat", 32'(beat), 32'd0);
        resetn = 1'b1;
        cyc(1);

        // Clear takes exactly STEPS cycles.
        pulse(3);
        chk("clear_busy_first", 32'(busy), 32'd1);
        chk("clear_mode", 32'(mode), 32'd3);
        cyc(3);
        chk("clear_busy_last", 32'(busy), 32'd1);
        cyc(1);
        chk("clear_done_mode", 32'(mode), 32'd0);
        chk("clear_done_busy", 32'(busy), 32'd0);

        pulse(2);
        play_pass(8'd0, 8'd0, 8'd0, 8'd0, 1);
        pulse(2);
        chk("stop_mode", 32'(mode), 32'd0);

        // Record 5, -, 12, -.
        pulse(1);
        chk("rec_mode", 32'(mode), 32'd2);
        note_in = 8'h05; cyc(4);
        chk("rec_step1", 32'(step_idx), 32'd1);
        chk("rec_beat1", 32'(beat), 32'd1);
        note_in = 8'h00; cyc(4);
        note_in = 8'h0C; cyc(4);
        note_in = 8'h00; cyc(3);
        pulse(1);
        chk("punch_out_mode", 32'(mode), 32'd1);
        chk("wrap_step", 32'(step_idx), 32'd0);
        chk("wrap_beat", 32'(beat), 32'd1);
        cyc(1);
        chk("beat_low", 32'(beat), 32'd0);
        cyc(3);
        chk("beat_period", 32'(beat), 32'd1);
        chk("beat_step", 32'(step_idx), 32'd1);
        cyc(12);
        play_pass(8'd5, 8'd0, 8'd12, 8'd0, 2);

        // Overdub 7 into step 1; a later 9 in the same step is ignored.
        pulse(1);
        cyc(3);
        note_in = 8'h07; cyc(2);
        note_in = 8'h09; cyc(2);
        note_in = 8'h00; cyc(4);
        cyc(3);
        pulse(1);
        play_pass(8'd5, 8'd7, 8'd12, 8'd0, 1);

        // Out-of-range notes are never stored or played.
        pulse(1);
        note_in = 8'h1B; cyc(3);
        cyc(4);
        note_in = 8'h00; cyc(4);
        cyc(3);
        pulse(1);
        play_pass(8'd5, 8'd7, 8'd12, 8'd0, 1);
        pulse(2);
        note_in = 8'h1B; cyc(1);
        chk("idle_sanitise", 32'(note_out), 32'd0);
        note_in = 8'h1A; cyc(1);
        chk("idle_max_note", 32'(note_out), 32'd26);
        note_in = 8'h00;

        // rec_p beats play_p; leaving REC commits the pending capture.
        rec_p = 1'b1; play_p = 1'b1; cyc(1);
        rec_p = 1'b0; play_p = 1'b0;
        chk("rec_over_play", 32'(mode), 32'd2);
        note_in = 8'h03; cyc(1);
        note_in = 8'h00;
        pulse(2);
        chk("exit_idle", 32'(mode), 32'd0);
        pulse(2);
        chk("exit_commit", 32'(note_out), 32'd3);
        cyc(4);
        chk("after_commit", 32'(note_out), 32'd7);

        // clear_p beats rec_p; every pulse during CLEAR is ignored.
        clear_p = 1'b1; rec_p = 1'b1; cyc(1);
        clear_p = 1'b0; rec_p = 1'b0;
        chk("clear_over_rec", 32'(mode), 32'd3);
        chk("clear_note", 32'(note_out), 32'd0);
        pulse(1); pulse(2); pulse(3); pulse(3);
        chk("lockout_mode", 32'(mode), 32'd0);
        chk("lockout_busy", 32'(busy), 32'd0);
        pulse(2);
        play_pass(8'd0, 8'd0, 8'd0, 8'd0, 1);
        pulse(2);

        // Reset mid-REC at step 1, timer 2: outputs drop without a clock edge.
        pulse(1);
        note_in = 8'h05; cyc(6);
        chk("pre_reset_mode", 32'(mode), 32'd2);
        chk("pre_reset_step", 32'(step_idx), 32'd1);
        chk("pre_reset_note", 32'(note_out), 32'd5);
        #2 resetn = 1'b0;
        #1;
        chk("async_mode", 32'(mode), 32'd0);
        chk("async_step", 32'(step_idx), 32'd0);
        chk("async_note", 32'(note_out), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        note_in = 8'h00;
        cyc(2);
        resetn = 1'b1;
        cyc(2);
        chk("post_reset_mode", 32'(mode), 32'd0);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
